// File: rtl/lsu_axi_pkg.sv
// Shared encodings for the load/store unit AXI write path: FSM states,
// AXI burst/response constants and the size-derived helpers.
package lsu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } store_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // The bus is 32 bits wide, so anything above 4-byte beats is clamped.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd2) ? 3'd2 : size;
  endfunction

  function automatic logic [3:0] size_to_strb(input logic [2:0] size);
    case (size)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// AXI write-channel bundle (AW, W, B) between the store buffer and the
// interconnect.
interface store_buffer_if;
  logic [7:0]  awid;
  logic [11:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/store_wdata_fifo.sv
// Two-entry write-data FIFO; head is the oldest entry and stays put
// while it is not popped.
module store_wdata_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [1:0]  count,
  output logic [31:0] head
);

  logic [31:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/store_buffer.sv
// Store buffer: takes one store command, prefetches the source words from
// SRAM into a 2-entry FIFO and emits them as a single AXI INCR write burst.
//
// state   | meaning
// IDLE    | ready for a command
// AW      | address phase outstanding; SRAM prefetch already running
// DATA    | streaming W beats from the FIFO
// RESP    | waiting for the B response
module store_buffer
  import lsu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_store_vld,
  output logic        ctrl_store_rdy,
  input  logic [7:0]  ctrl_store_id,
  input  logic [11:0] ctrl_store_dram_addr,
  input  logic [7:0]  ctrl_store_len,
  input  logic [2:0]  ctrl_store_size,
  input  logic [11:0] ctrl_store_st_addr,
  output logic        store_done,
  output logic        store_err,
  output logic        store_sram_vld,
  output logic [7:0]  store_sram_addr,
  input  logic [31:0] sram_store_dout,
  store_buffer_if.master axi
);

  store_state_e state, state_nxt;

  logic [7:0]  id_q;
  logic [11:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [7:0]  st_q;
  logic [8:0]  rd_cnt;
  logic [7:0]  beat_cnt;
  logic        rd_inflight;
  logic        rd_req;
  logic        w_fire;
  logic        cmd_fire;
  logic [1:0]  fifo_count;
  logic [31:0] fifo_head;
  logic        unused_st_addr_hi;

  assign unused_st_addr_hi = ^ctrl_store_st_addr[11:8];

  always_comb begin
    state_nxt      = state;
    ctrl_store_rdy = 1'b0;
    axi.awvalid    = 1'b0;
    axi.wvalid     = 1'b0;
    axi.bready     = 1'b0;
    rd_req         = 1'b0;
    w_fire         = 1'b0;
    // Reads never exceed what the FIFO can absorb, counting the one in flight.
    if ((state == ST_AW || state == ST_DATA) && (rd_cnt <= {1'b0, len_q}) &&
        (({1'b0, fifo_count} + {2'b00, rd_inflight}) < 3'd2))
      rd_req = 1'b1;
    case (state)
      ST_IDLE: begin
        ctrl_store_rdy = 1'b1;
        if (ctrl_store_vld) state_nxt = ST_AW;
      end
      ST_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        axi.wvalid = (fifo_count != 2'd0);
        w_fire     = axi.wvalid && axi.wready;
        if (w_fire && axi.wlast) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_fire = ctrl_store_vld && ctrl_store_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rd_cnt      <= 9'd0;
      beat_cnt    <= 8'd0;
      rd_inflight <= 1'b0;
      store_done  <= 1'b0;
      store_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= rd_req;
      store_done  <= axi.bready && axi.bvalid;
      store_err   <= axi.bready && axi.bvalid &&
                     ((axi.bresp != AXI_RESP_OKAY) || (axi.bid != id_q));
      if (cmd_fire) begin
        rd_cnt   <= 9'd0;
        beat_cnt <= 8'd0;
      end else begin
        if (rd_req) rd_cnt <= rd_cnt + 9'd1;
        if (w_fire) beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      id_q   <= ctrl_store_id;
      addr_q <= ctrl_store_dram_addr;
      len_q  <= ctrl_store_len;
      size_q <= ctrl_store_size;
      st_q   <= ctrl_store_st_addr[7:0];
    end
  end

  assign store_sram_vld  = rd_req;
  assign store_sram_addr = st_q + rd_cnt[7:0];

  store_wdata_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_inflight),
    .pop   (w_fire),
    .din   (sram_store_dout),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = clamp_size(size_q);
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = fifo_head;
  assign axi.wstrb   = size_to_strb(size_q);
  assign axi.wlast   = (beat_cnt == len_q);

endmodule
